// File: rtl/cpu_consts.sv
// Shared CPU constants: memory access sizes plus the memory-port arbiter's
// state and owner encodings, and the alignment rule used by the lane aligner.
package cpu_consts;

    typedef enum logic [1:0] {
        BYTE        = 2'd0,
        HALF_WORD   = 2'd1,
        WORD        = 2'd2,
        DOUBLE_WORD = 2'd3
    } mem_access_size_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_INSTR = 1'b0,
        OWN_DATA  = 1'b1
    } arb_owner_t;

    localparam int unsigned DATA_W = 32;

    // A 32-bit port cannot carry a double word, so that size is always rejected.
    function automatic logic is_misaligned(input mem_access_size_t size,
                                           input logic [1:0] off);
        logic mis;
        case (size)
            BYTE:        mis = 1'b0;
            HALF_WORD:   mis = off[0];
            WORD:        mis = (off != 2'b00);
            DOUBLE_WORD: mis = 1'b1;
            default:     mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Downstream memory bus of the arbiter: request/grant plus response channel.
// The arbiter drives it through the master modport, the memory through slave.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_wr_o;
    logic [3:0]        mem_be_o;
    logic [31:0]       mem_wdata_o;
    logic              mem_gnt_i;
    logic              mem_rvalid_i;
    logic [31:0]       mem_rdata_i;

    modport master (
        output mem_req_o,
        output mem_addr_o,
        output mem_wr_o,
        output mem_be_o,
        output mem_wdata_o,
        input  mem_gnt_i,
        input  mem_rvalid_i,
        input  mem_rdata_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_addr_o,
        input  mem_wr_o,
        input  mem_be_o,
        input  mem_wdata_o,
        output mem_gnt_i,
        output mem_rvalid_i,
        output mem_rdata_i
    );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic for a 32-bit port: byte enables and lane
// replication for stores, shift-down and sign/zero extension for loads, and
// the alignment check.
module mem_lane_align
    import cpu_consts::*;
(
    input  mem_access_size_t size_i,
    input  logic [1:0]       addr_lo_i,
    input  logic             zero_extnd_i,
    input  logic [31:0]      wdata_i,
    input  logic [31:0]      rdata_i,
    output logic [3:0]       be_o,
    output logic [31:0]      wdata_o,
    output logic [31:0]      rdata_o,
    output logic             misaligned_o
);

    // Addressed byte/half moved down to lane 0; upper lanes are never needed.
    logic [15:0] lane_s;
    assign lane_s = 16'(rdata_i >> {addr_lo_i, 3'b000});

    assign misaligned_o = is_misaligned(size_i, addr_lo_i);

    // Per-size lane enables, store replication and load extension.
    always_comb begin
        be_o    = 4'h0;
        wdata_o = 32'h0000_0000;
        rdata_o = 32'h0000_0000;
        case (size_i)
            BYTE: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
                if (zero_extnd_i) begin
                    rdata_o = {24'h00_0000, lane_s[7:0]};
                end else begin
                    rdata_o = {{24{lane_s[7]}}, lane_s[7:0]};
                end
            end
            HALF_WORD: begin
                be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
                wdata_o = {2{wdata_i[15:0]}};
                if (zero_extnd_i) begin
                    rdata_o = {16'h0000, lane_s};
                end else begin
                    rdata_o = {{16{lane_s[15]}}, lane_s};
                end
            end
            WORD: begin
                be_o    = 4'hF;
                wdata_o = wdata_i;
                rdata_o = rdata_i;
            end
            default: begin
                be_o    = 4'h0;
                wdata_o = 32'h0000_0000;
                rdata_o = 32'h0000_0000;
            end
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// Data wins arbitration; one transaction outstanding; responses go back to
// the registered owner. Optional fetch-starvation guard: define
// MEM_ARB_FAIR_EN to let fetch win after STARVE_MAX back-to-back data grants.
module mem_port_arbiter
    import cpu_consts::*;
#(
    parameter int ADDR_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              instr_req,
    input  logic [ADDR_W-1:0] instr_addr,
    output logic              instr_rsp_valid,
    output logic [31:0]       instr_rdata,

    input  logic              data_req,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic              data_wr,
    input  mem_access_size_t  data_byte,
    input  logic              data_zero_extnd,
    input  logic [31:0]       data_wdata,
    output logic              data_rsp_valid,
    output logic [31:0]       data_rdata,
    output logic              data_err,

    mem_port_arbiter_if.master mem
);

    arb_state_t        state_q, state_d;
    arb_owner_t        owner_q, owner_d;
    mem_access_size_t  size_q, size_d;
    logic [1:0]        addr_lo_q, addr_lo_d;
    logic              wr_q, wr_d;
    logic              zext_q, zext_d;

    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_wr_q, mem_wr_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    logic              instr_rsp_valid_q, instr_rsp_valid_d;
    logic [31:0]       instr_rdata_q, instr_rdata_d;
    logic              data_rsp_valid_q, data_rsp_valid_d;
    logic [31:0]       data_rdata_q, data_rdata_d;
    logic              data_err_q, data_err_d;

    logic              pick_data_s;
    logic              fetch_force_s;

    mem_access_size_t  al_size_s;
    logic [1:0]        al_addr_s;
    logic              al_zext_s;
    logic [31:0]       al_wdata_in_s;
    logic [3:0]        al_be_s;
    logic [31:0]       al_wdata_s;
    logic [31:0]       al_rdata_s;
    logic              al_mis_s;

    // Fetch addresses are word-aligned by contract; their low bits are dropped.
    logic [1:0]        unused_instr_lo_s;
    assign unused_instr_lo_s = instr_addr[1:0];

`ifdef MEM_ARB_FAIR_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_q, starve_d;

    assign fetch_force_s = instr_req && data_req && (starve_q == CNT_W'(STARVE_MAX));

    // Count data grants made over a waiting fetch; any fetch grant clears it.
    always_comb begin
        starve_d = starve_q;
        if (state_q == IDLE) begin
            if (pick_data_s && instr_req) begin
                if (starve_q != CNT_W'(STARVE_MAX)) begin
                    starve_d = starve_q + CNT_W'(1);
                end else begin
                    starve_d = starve_q;
                end
            end else if (instr_req) begin
                starve_d = '0;
            end else begin
                starve_d = starve_q;
            end
        end else begin
            starve_d = starve_q;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign fetch_force_s = 1'b0;

    logic [31:0] unused_starve_s;
    assign unused_starve_s = 32'(STARVE_MAX);
`endif

    assign pick_data_s = data_req && !fetch_force_s;

    // In IDLE the aligner sees the arbitration winner; afterwards the held request.
    always_comb begin
        if (state_q == IDLE) begin
            if (pick_data_s) begin
                al_size_s     = data_byte;
                al_addr_s     = data_addr[1:0];
                al_zext_s     = data_zero_extnd;
                al_wdata_in_s = data_wdata;
            end else begin
                al_size_s     = WORD;
                al_addr_s     = 2'b00;
                al_zext_s     = 1'b0;
                al_wdata_in_s = 32'h0000_0000;
            end
        end else begin
            al_size_s     = size_q;
            al_addr_s     = addr_lo_q;
            al_zext_s     = zext_q;
            al_wdata_in_s = 32'h0000_0000;
        end
    end

    mem_lane_align u_lane_align (
        .size_i       (al_size_s),
        .addr_lo_i    (al_addr_s),
        .zero_extnd_i (al_zext_s),
        .wdata_i      (al_wdata_in_s),
        .rdata_i      (mem.mem_rdata_i),
        .be_o         (al_be_s),
        .wdata_o      (al_wdata_s),
        .rdata_o      (al_rdata_s),
        .misaligned_o (al_mis_s)
    );

    // Arbitration, request issue, response capture and response pulse.
    always_comb begin
        state_d           = state_q;
        owner_d           = owner_q;
        size_d            = size_q;
        addr_lo_d         = addr_lo_q;
        wr_d              = wr_q;
        zext_d            = zext_q;
        mem_req_d         = mem_req_q;
        mem_addr_d        = mem_addr_q;
        mem_wr_d          = mem_wr_q;
        mem_be_d          = mem_be_q;
        mem_wdata_d       = mem_wdata_q;
        instr_rsp_valid_d = 1'b0;
        instr_rdata_d     = instr_rdata_q;
        data_rsp_valid_d  = 1'b0;
        data_rdata_d      = data_rdata_q;
        data_err_d        = data_err_q;
        case (state_q)
            IDLE: begin
                if (pick_data_s) begin
                    owner_d   = OWN_DATA;
                    size_d    = data_byte;
                    addr_lo_d = data_addr[1:0];
                    wr_d      = data_wr;
                    zext_d    = data_zero_extnd;
                    if (al_mis_s) begin
                        state_d          = RESP;
                        data_rsp_valid_d = 1'b1;
                        data_err_d       = 1'b1;
                        data_rdata_d     = 32'h0000_0000;
                    end else begin
                        state_d     = ISSUE;
                        mem_req_d   = 1'b1;
                        mem_addr_d  = {data_addr[ADDR_W-1:2], 2'b00};
                        mem_wr_d    = data_wr;
                        mem_be_d    = al_be_s;
                        mem_wdata_d = data_wr ? al_wdata_s : 32'h0000_0000;
                    end
                end else if (instr_req) begin
                    owner_d     = OWN_INSTR;
                    size_d      = WORD;
                    addr_lo_d   = 2'b00;
                    wr_d        = 1'b0;
                    zext_d      = 1'b0;
                    state_d     = ISSUE;
                    mem_req_d   = 1'b1;
                    mem_addr_d  = {instr_addr[ADDR_W-1:2], 2'b00};
                    mem_wr_d    = 1'b0;
                    mem_be_d    = al_be_s;
                    mem_wdata_d = 32'h0000_0000;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (mem.mem_gnt_i) begin
                    mem_req_d = 1'b0;
                    state_d   = WAIT;
                end else begin
                    state_d = ISSUE;
                end
            end
            WAIT: begin
                if (mem.mem_rvalid_i) begin
                    state_d = RESP;
                    if (owner_q == OWN_DATA) begin
                        data_rsp_valid_d = 1'b1;
                        data_err_d       = 1'b0;
                        data_rdata_d     = wr_q ? 32'h0000_0000 : al_rdata_s;
                    end else begin
                        instr_rsp_valid_d = 1'b1;
                        instr_rdata_d     = mem.mem_rdata_i;
                    end
                end else begin
                    state_d = WAIT;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM and registered-output flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q           <= IDLE;
            owner_q           <= OWN_INSTR;
            size_q            <= BYTE;
            addr_lo_q         <= 2'b00;
            wr_q              <= 1'b0;
            zext_q            <= 1'b0;
            mem_req_q         <= 1'b0;
            mem_addr_q        <= '0;
            mem_wr_q          <= 1'b0;
            mem_be_q          <= 4'h0;
            mem_wdata_q       <= 32'h0000_0000;
            instr_rsp_valid_q <= 1'b0;
            instr_rdata_q     <= 32'h0000_0000;
            data_rsp_valid_q  <= 1'b0;
            data_rdata_q      <= 32'h0000_0000;
            data_err_q        <= 1'b0;
        end else begin
            state_q           <= state_d;
            owner_q           <= owner_d;
            size_q            <= size_d;
            addr_lo_q         <= addr_lo_d;
            wr_q              <= wr_d;
            zext_q            <= zext_d;
            mem_req_q         <= mem_req_d;
            mem_addr_q        <= mem_addr_d;
            mem_wr_q          <= mem_wr_d;
            mem_be_q          <= mem_be_d;
            mem_wdata_q       <= mem_wdata_d;
            instr_rsp_valid_q <= instr_rsp_valid_d;
            instr_rdata_q     <= instr_rdata_d;
            data_rsp_valid_q  <= data_rsp_valid_d;
            data_rdata_q      <= data_rdata_d;
            data_err_q        <= data_err_d;
        end
    end

    assign mem.mem_req_o   = mem_req_q;
    assign mem.mem_addr_o  = mem_addr_q;
    assign mem.mem_wr_o    = mem_wr_q;
    assign mem.mem_be_o    = mem_be_q;
    assign mem.mem_wdata_o = mem_wdata_q;

    assign instr_rsp_valid = instr_rsp_valid_q;
    assign instr_rdata     = instr_rdata_q;
    assign data_rsp_valid  = data_rsp_valid_q;
    assign data_rdata      = data_rdata_q;
    assign data_err        = data_err_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the CPU's single memory port between the instruction-fetch requester and the load/store requester. Arbitrates, registers the winning request, drives the downstream request/grant/response handshake with one transaction outstanding, and returns the response to the owner. It performs byte-lane steering for stores and alignment plus sign/zero extension for loads. It sits between the fetch/LSU stages and the memory/bus interface.

## Interface
- ADDR_W, 32, address width; data width is fixed at 32
- STARVE_MAX, 4, consecutive data grants allowed while fetch waits (fairness build only)

- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- instr_req  in  1  fetch request; held until instr_rsp_valid
- instr_addr  in  ADDR_W  fetch address; word-aligned, always a WORD read
- instr_rsp_valid  out  1  one-cycle response pulse
- instr_rdata  out  32  fetched word
- data_req  in  1  load/store request; held until data_rsp_valid
- data_addr  in  ADDR_W  byte address
- data_wr  in  1  1 = store
- data_byte  in  2  mem_access_size_t
- data_zero_extnd  in  1  load zero-extends when 1, sign-extends when 0
- data_wdata  in  32  store data, right-justified
- data_rsp_valid  out  1  one-cycle response pulse
- data_rdata  out  32  aligned, extended load data
- data_err  out  1  misaligned or unsupported size; valid with data_rsp_valid
- mem_req_o  out  1  downstream request, held until mem_gnt_i
- mem_addr_o  out  ADDR_W  word-aligned address (addr[1:0] forced to 0)
- mem_wr_o  out  1  write enable
- mem_be_o  out  4  byte enables
- mem_wdata_o  out  32  lane-replicated store data
- mem_gnt_i  in  1  request accepted
- mem_rvalid_i  in  1  response valid, for reads and writes
- mem_rdata_i  in  32  raw read word

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: samples both requests.
  - Data wins over fetch by default.
  - The winner's address, wr, size, zero_extnd and wdata are registered, along with the owner.
  - Go to ISSUE. For a data request that fails the alignment check, go straight to RESP with err=1 and no memory access.
- Misaligned cases:
  - HALF_WORD with addr[0]=1
  - WORD with addr[1:0]≠0
  - DOUBLE_WORD at any address
- ISSUE: mem_req_o=1 with stable registered fields. On mem_gnt_i, go to WAIT.
- WAIT: mem_rvalid_i captures mem_rdata_i and moves to RESP. mem_rvalid_i is ignored in every other state.
- RESP: the owner's rsp_valid is high for exactly one cycle, then IDLE.
  - The requester must deassert or replace its request during RESP.
  - Requests are not sampled in RESP.
- Byte enables:
  - BYTE: 4'b0001<<addr[1:0]
  - HALF_WORD: 4'b0011<<{addr[1],1'b0}
  - WORD: 4'b1111
- Store data: wdata[7:0] is replicated to all four lanes for BYTE; wdata[15:0] is replicated to both halves for HALF_WORD.
- Load data: the addressed byte or half is shifted down, then zero- or sign-extended to 32 bits.
- Stores return data_rdata=0.
- Fetch responses return mem_rdata_i unmodified.

## Timing
- Reset values:
  - state IDLE
  - all outputs 0
  - fairness counter 0
- Reset mid-transaction abandons the transaction. Any late mem_rvalid_i is ignored because the FSM is in IDLE.
- Minimum latency, with gnt in the first ISSUE cycle and rvalid one cycle later:
  - cycle 0: req seen in IDLE
  - cycle 1: mem_req_o asserted, gnt
  - cycle 2: mem_rvalid_i
  - cycle 3: rsp_valid
- Misaligned data error: rsp_valid and err at cycle 1.
- Simultaneous requests in IDLE resolve by the priority rule. The loser's request stays pending and is served after RESP.
- data_rdata, instr_rdata and data_err are held stable from RESP until the next RESP.

## Configuration
- MEM_ARB_FAIR_EN defined:
  - A saturating counter increments on each data grant made while instr_req is high.
  - It clears on any fetch grant.
  - When the count equals STARVE_MAX and both requests are pending, fetch wins.
- MEM_ARB_FAIR_EN undefined: strict data priority, no counter logic.

## Structure
- Added to package cpu_consts:
  - arb_state_t (IDLE/ISSUE/WAIT/RESP)
  - arb_owner_t (OWN_INSTR/OWN_DATA)
- The block reuses mem_access_size_t from cpu_consts.
- One combinational sub-module, mem_lane_align:
  - inputs: size, addr[1:0], zero_extnd, wdata, raw rdata
  - outputs: be, replicated wdata, extended rdata, misaligned flag

## Test plan
- Fetch only: instr_addr=0x100, gnt at cycle 1, rvalid at cycle 2 with 0xDEADBEEF → instr_rsp_valid at cycle 3, instr_rdata=0xDEADBEEF, mem_be_o=4'hF.
- Signed byte load: addr=0x203, size BYTE, zero_extnd=0, mem_rdata_i=0x80112233 → mem_be_o=4'b1000, data_rdata=0xFFFFFF80.
- Half store: addr=0x102, wdata=0x0000ABCD → mem_be_o=4'b1100, mem_wdata_o=0xABCDABCD, mem_addr_o=0x100.
- Misaligned WORD load at 0x101 → data_rsp_valid and data_err at cycle 1, mem_req_o never asserted.
- Both requests held continuously:
  - Strict build: data wins every arbitration.
  - MEM_ARB_FAIR_EN build: fetch wins after STARVE_MAX=4 data grants.
- Reset asserted during WAIT, then mem_rvalid_i pulses → no rsp_valid, state IDLE, all outputs 0.
